// File: rtl/z80_uart_rxbuf_if.sv
// Signal bundle between the receive buffer, the uart_rx byte receiver and the Z80 I/O read path.
// slave is the buffer's view; master is the view of whatever drives it.
interface z80_uart_rxbuf_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_data;
    logic                rx_data_ready;
    logic                rx_clear;
    logic                io_rd_data;
    logic                io_rd_stat;
    logic                int_ack;
    logic                int_en;
    logic [7:0]          rd_data;
    logic [7:0]          status;
    logic [DEPTH_LOG2:0] count;
    logic                int_n;

    modport slave (
        input  rx_data, rx_data_ready, io_rd_data, io_rd_stat, int_ack, int_en,
        output rx_clear, rd_data, status, count, int_n
    );

    modport master (
        output rx_data, rx_data_ready, io_rd_data, io_rd_stat, int_ack, int_en,
        input  rx_clear, rd_data, status, count, int_n
    );
endinterface

// File: rtl/z80_uart_rxbuf.sv
// UART receive FIFO. Bytes from uart_rx are captured through a ready/clear handshake.
// The CPU reads the FIFO head, a status byte and a masked level interrupt.
module z80_uart_rxbuf #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] EMPTY_DATA = 8'h00
) (
    input  logic               clk,
    input  logic               reset_n,
    z80_uart_rxbuf_if.slave    bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t                state, state_nx;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [DEPTH_LOG2:0]   count;
    logic [7:0]            rd_data;
    logic                  overrun, mask, int_n;
    logic                  rd_q, stat_q, ack_q;
    logic                  full, not_empty;
    logic                  pop_edge, stat_edge, ack_edge, pop;
    logic                  take, push, drop, rx_clear;

    assign full      = (count == FULL_CNT);
    assign not_empty = (count != '0);
    assign pop_edge  = bus.io_rd_data & ~rd_q;
    assign stat_edge = bus.io_rd_stat & ~stat_q;
    assign ack_edge  = bus.int_ack & ~ack_q;
    assign pop       = pop_edge & not_empty;

    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign push = take & (~full | pop);
    assign drop = take & full & ~pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        rx_clear = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_data_ready) begin
                    take     = 1'b1;
                    state_nx = CLEARING;
                end
            end
            CLEARING: begin
                rx_clear = 1'b1;
                if (!bus.rx_data_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
            mask    <= 1'b0;
            rd_q    <= 1'b0;
            stat_q  <= 1'b0;
            ack_q   <= 1'b0;
            rd_data <= EMPTY_DATA;
            int_n   <= 1'b1;
        end else begin
            rd_q   <= bus.io_rd_data;
            stat_q <= bus.io_rd_stat;
            ack_q  <= bus.int_ack;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            // rd_data only moves on a read edge so it stays stable over the CPU cycle.
            if (pop_edge) rd_data <= not_empty ? mem[rptr] : EMPTY_DATA;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)           overrun <= 1'b1;
            else if (stat_edge) overrun <= 1'b0;
            if (ack_edge)       mask <= 1'b1;
            else if (pop_edge)  mask <= 1'b0;
            int_n <= ~(not_empty & bus.int_en & ~mask);
        end
    end

    assign bus.rx_clear = rx_clear;
    assign bus.rd_data  = rd_data;
    assign bus.status   = {overrun, 3'b000, full, 1'b0, not_empty, 1'b0};
    assign bus.count    = count;
    assign bus.int_n    = int_n;
endmodule

// File: tb/tb_z80_uart_rxbuf.sv
// Scoreboard bench for z80_uart_rxbuf: a queue model of the FIFO predicts read data,
// count, status and interrupt; a separate monitor checks every data-read edge.
module tb_z80_uart_rxbuf;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    z80_uart_rxbuf_if #(.DEPTH_LOG2(4)) bus();

    z80_uart_rxbuf #(.DEPTH_LOG2(4), .EMPTY_DATA(8'h00)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic [7:0] expq[$];
    bit m_ovr  = 1'b0;
    bit m_mask = 1'b0;
    bit mon_pend = 1'b0;
    bit mon_last = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag);
        logic [7:0] es;
        es = {m_ovr, 3'b000, mq.size() == 16, 1'b0, mq.size() != 0, 1'b0};
        chk({tag, ".count"},  32'(bus.count), mq.size());
        chk({tag, ".status"}, 32'(bus.status), 32'(es));
        chk({tag, ".int_n"},  32'(bus.int_n),
            32'(!(mq.size() != 0 && bus.int_en && !m_mask)));
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr  = 1'b0;
        m_mask = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        bus.rx_data = d;
        bus.rx_data_ready = 1'b1;
        if (mq.size() < 16) mq.push_back(d);
        else                m_ovr = 1'b1;
        step();
        chk("rx_clear_rise", 32'(bus.rx_clear), 1);
        bus.rx_data_ready = 1'b0;
        step();
        chk("rx_clear_fall", 32'(bus.rx_clear), 0);
    endtask

    task automatic pop_byte();
        expq.push_back(mq.size() != 0 ? mq.pop_front() : 8'h00);
        m_mask = 1'b0;
        bus.io_rd_data = 1'b1;
        step();
        bus.io_rd_data = 1'b0;
        step();
    endtask

    task automatic stat_read();
        bus.io_rd_stat = 1'b1;
        step();
        bus.io_rd_stat = 1'b0;
        m_ovr = 1'b0;
        step();
    endtask

    task automatic ack_pulse();
        bus.int_ack = 1'b1;
        step();
        bus.int_ack = 1'b0;
        m_mask = 1'b1;
        step();
    endtask

    // Monitor: one negedge after a rising io_rd_data, rd_data must hold the predicted byte.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_pend) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: rd_data=%0h with no expected entry", bus.rd_data);
                end else begin
                    chk("rd_data", 32'(bus.rd_data), 32'(expq.pop_front()));
                end
            end
            mon_pend = bus.io_rd_data && !mon_last;
            mon_last = bus.io_rd_data;
        end
    end

    initial begin
        logic [7:0] held;
        int nchg;
        bus.rx_data = 8'h00;
        bus.rx_data_ready = 1'b0;
        bus.io_rd_data = 1'b0;
        bus.io_rd_stat = 1'b0;
        bus.int_ack = 1'b0;
        bus.int_en = 1'b1;
        repeat (3) step();
        chk("rst.rx_clear", 32'(bus.rx_clear), 0);
        chk("rst.rd_data",  32'(bus.rd_data), 32'h00);
        chk("rst.int_n",    32'(bus.int_n), 1);
        reset_n = 1'b1;
        step();
        chk_state("reset");

        // single byte round trip
        push_byte(8'h41);
        step();
        chk_state("one_byte");
        pop_byte();
        chk_state("one_byte_pop");

        // fill, overrun, status clear, drain
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        step();
        chk_state("full");
        push_byte(8'hFF);
        step();
        chk_state("overrun");
        stat_read();
        chk_state("stat_clear");
        for (int i = 0; i < 16; i++) pop_byte();
        chk_state("drained");

        // held read pops exactly once
        for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
        expq.push_back(mq.pop_front());
        m_mask = 1'b0;
        bus.io_rd_data = 1'b1;
        step();
        held = bus.rd_data;
        nchg = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (bus.rd_data !== held) nchg++;
        end
        bus.io_rd_data = 1'b0;
        step();
        chk("hold_stable", 32'(nchg), 0);
        chk_state("hold");
        pop_byte();
        pop_byte();

        // empty read then recovery
        pop_byte();
        chk_state("empty_pop");
        push_byte(8'h5C);
        pop_byte();
        chk_state("after_empty");

        // full with simultaneous pop and push
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        expq.push_back(mq.pop_front());
        mq.push_back(8'hA5);
        m_mask = 1'b0;
        bus.rx_data = 8'hA5;
        bus.rx_data_ready = 1'b1;
        bus.io_rd_data = 1'b1;
        step();
        bus.io_rd_data = 1'b0;
        chk("conc.rx_clear", 32'(bus.rx_clear), 1);
        bus.rx_data_ready = 1'b0;
        step();
        step();
        chk_state("concurrent");
        for (int i = 0; i < 16; i++) pop_byte();

        // interrupt masking
        push_byte(8'h11);
        push_byte(8'h22);
        step();
        chk_state("int_two");
        ack_pulse();
        chk_state("int_acked");
        pop_byte();
        chk_state("int_rearm");
        pop_byte();
        chk_state("int_empty");
        push_byte(8'h33);
        bus.int_en = 1'b0;
        step();
        chk_state("int_disabled");
        bus.int_en = 1'b1;
        pop_byte();

        // randomized mix against the queue model
        for (int n = 0; n < 200; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3)      push_byte(8'($urandom));
            else if (op <= 6) pop_byte();
            else if (op == 7) stat_read();
            else if (op == 8) ack_pulse();
            else begin
                bus.int_en = 1'($urandom_range(0, 1));
                step();
                step();
            end
            chk_state("rand");
        end
        bus.int_en = 1'b1;

        // reset in the middle of a handshake
        bus.rx_data = 8'h77;
        bus.rx_data_ready = 1'b1;
        step();
        chk("mid.rx_clear_before", 32'(bus.rx_clear), 1);
        reset_n = 1'b0;
        #1;
        chk("mid.rx_clear", 32'(bus.rx_clear), 0);
        chk("mid.count", 32'(bus.count), 0);
        bus.rx_data_ready = 1'b0;
        model_reset();
        step();
        reset_n = 1'b1;
        step();
        chk_state("post_reset");

        step();
        step();
        chk("scoreboard_empty", 32'(expq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
